// File: rtl/float_triplet_sort_stream.sv
// Stream adapter: packs three serial floats into a triplet, sorts them through
// sort_three_floats, and re-emits them in ascending order with a last marker.

module sort_three_floats #(
   parameter int FLEN = 64
) (
   input  logic [2:0][FLEN-1:0] unsorted,
   output logic [2:0][FLEN-1:0] sorted,
   output logic                 err
);

   function automatic logic is_nan(input logic [FLEN-1:0] v);
      return (&v[FLEN-2:52]) && (|v[51:0]);
   endfunction

   // Sign-magnitude ordering; -0.0 and +0.0 compare equal.
   function automatic logic le(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
      logic             sa, sb;
      logic [FLEN-2:0]  ma, mb;
      sa = a[FLEN-1];
      sb = b[FLEN-1];
      ma = a[FLEN-2:0];
      mb = b[FLEN-2:0];
      if (sa && sb)
         return ma >= mb;
      else if (sa && !sb)
         return 1'b1;
      else if (!sa && sb)
         return (ma == '0) && (mb == '0);
      else
         return ma <= mb;
   endfunction

   logic [2:0][FLEN-1:0] s;
   logic [FLEN-1:0]      t;

   // Three-comparator bubble network; swaps only on strict inversion so equal keys stay in order.
   always_comb begin
      s = unsorted;
      t = '0;
      if (!le(s[0], s[1])) begin
         t = s[0]; s[0] = s[1]; s[1] = t;
      end
      if (!le(s[1], s[2])) begin
         t = s[1]; s[1] = s[2]; s[2] = t;
      end
      if (!le(s[0], s[1])) begin
         t = s[0]; s[0] = s[1]; s[1] = t;
      end
      sorted = s;
      err    = is_nan(unsorted[0]) | is_nan(unsorted[1]) | is_nan(unsorted[2]);
   end

endmodule

module float_triplet_sort_stream #(
   parameter int FLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            up_valid,
   output logic            up_ready,
   input  logic [FLEN-1:0] up_data,
   output logic            down_valid,
   input  logic            down_ready,
   output logic [FLEN-1:0] down_data,
   output logic            down_last,
   output logic            down_err
);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      SORT = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t               state, state_d;
   logic [1:0]           idx, idx_d;
   logic                 rdy_q;
   logic [2:0][FLEN-1:0] fill_buf;
   logic [2:0][FLEN-1:0] sorted_q;
   logic [2:0][FLEN-1:0] sorted;
   logic                 err_q, err;
   logic                 up_fire, down_fire;
   logic [1:0]           slot;

   // Index 3 is never reached; decode it as 0 for safety.
   function automatic logic [1:0] slot_of(input logic [1:0] i);
      return (i == 2'd3) ? 2'd0 : i;
   endfunction

   sort_three_floats #(.FLEN(FLEN)) u_sort (
      .unsorted (fill_buf),
      .sorted   (sorted),
      .err      (err)
   );

   assign slot       = slot_of(idx);
   assign up_ready   = (state == FILL) && rdy_q;
   assign up_fire    = up_valid && up_ready;
   assign down_valid = (state == EMIT);
   assign down_fire  = down_valid && down_ready;
   assign down_data  = down_valid ? sorted_q[slot] : '0;
   assign down_last  = down_valid && (slot == 2'd2);
   assign down_err   = down_valid && err_q;

   always_comb begin
      state_d = state;
      idx_d   = idx;
      unique case (state)
         FILL: begin
            if (up_fire) begin
               if (slot == 2'd2) begin
                  idx_d   = 2'd0;
                  state_d = SORT;
               end else begin
                  idx_d = slot + 2'd1;
               end
            end
         end
         SORT: begin
            state_d = EMIT;
         end
         EMIT: begin
            if (down_fire) begin
               if (slot == 2'd2) begin
                  idx_d   = 2'd0;
                  state_d = FILL;
               end else begin
                  idx_d = slot + 2'd1;
               end
            end
         end
         default: begin
            state_d = FILL;
            idx_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         idx   <= 2'd0;
         rdy_q <= 1'b0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         rdy_q <= 1'b1;
      end
   end

   // Triplet capture and sorter result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_buf <= '0;
         sorted_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (up_fire)
            fill_buf[slot] <= up_data;
         if (state == SORT) begin
            sorted_q <= sorted;
            err_q    <= err;
         end
      end
   end

endmodule

// File: tb/tb_float_triplet_sort_stream.sv
// Directed bench for float_triplet_sort_stream: sorting, backpressure, NaN flag,
// upstream gaps and asynchronous reset mid-emission.

module tb_float_triplet_sort_stream;

   localparam logic [63:0] P1  = 64'h3FF0000000000000;
   localparam logic [63:0] P2  = 64'h4000000000000000;
   localparam logic [63:0] P3  = 64'h4008000000000000;
   localparam logic [63:0] M1  = 64'hBFF0000000000000;
   localparam logic [63:0] NAN = 64'h7FF8000000000000;
   localparam logic [63:0] JNK = 64'hDEADBEEFCAFEF00D;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        up_valid = 1'b0;
   logic        up_ready;
   logic [63:0] up_data = '0;
   logic        down_valid;
   logic        down_ready = 1'b0;
   logic [63:0] down_data;
   logic        down_last;
   logic        down_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   float_triplet_sort_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_last  (down_last),
      .down_err   (down_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] w, input string tag);
      int n = 0;
      up_valid = 1'b1;
      up_data  = w;
      while (!up_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_accept"}, up_ready, 1'b1);
      @(posedge clk); #1;
      up_valid = 1'b0;
      up_data  = JNK;
   endtask

   task automatic pop(input logic [63:0] d, input logic last, input logic e,
                      input bit chk_d, input string tag);
      int n = 0;
      down_ready = 1'b1;
      while (!down_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_vld"}, down_valid, 1'b1);
      if (chk_d) check({tag, "_data"}, down_data, d);
      check({tag, "_last"}, down_last, last);
      check({tag, "_err"}, down_err, e);
      check({tag, "_upr"}, up_ready, 1'b0);
      @(posedge clk); #1;
      down_ready = 1'b0;
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_upr", up_ready, 1'b0);
      check("rst_vld", down_valid, 1'b0);
      check("rst_data", down_data, 64'h0);
      check("rst_last", down_last, 1'b0);
      check("rst_err", down_err, 1'b0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_upr", up_ready, 1'b1);

      // Basic sort with latency.
      push(P3, "b0");
      push(P1, "b1");
      push(P2, "b2");
      check("lat_sort_vld", down_valid, 1'b0);
      check("lat_sort_upr", up_ready, 1'b0);
      @(posedge clk); #1;
      check("lat_emit_vld", down_valid, 1'b1);
      pop(P1, 1'b0, 1'b0, 1, "basic0");
      pop(P2, 1'b0, 1'b0, 1, "basic1");
      pop(P3, 1'b1, 1'b0, 1, "basic2");
      check("basic_back_fill", up_ready, 1'b1);

      // Negative, already sorted.
      push(M1, "n0"); push(P1, "n1"); push(P2, "n2");
      pop(M1, 1'b0, 1'b0, 1, "neg0");
      pop(P1, 1'b0, 1'b0, 1, "neg1");
      pop(P2, 1'b1, 1'b0, 1, "neg2");

      // Reverse order.
      push(P2, "r0"); push(P1, "r1"); push(M1, "r2");
      pop(M1, 1'b0, 1'b0, 1, "rev0");
      pop(P1, 1'b0, 1'b0, 1, "rev1");
      pop(P2, 1'b1, 1'b0, 1, "rev2");

      // Backpressure at beat 1.
      push(P3, "k0"); push(P2, "k1"); push(P1, "k2");
      pop(P1, 1'b0, 1'b0, 1, "bp0");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_vld", down_valid, 1'b1);
         check("bp_hold_data", down_data, P2);
         check("bp_hold_last", down_last, 1'b0);
         check("bp_hold_err", down_err, 1'b0);
         check("bp_hold_upr", up_ready, 1'b0);
         @(posedge clk); #1;
      end
      pop(P2, 1'b0, 1'b0, 1, "bp1");
      pop(P3, 1'b1, 1'b0, 1, "bp2");

      // NaN raises err on every beat; next clean triplet clears it.
      push(P1, "e0"); push(NAN, "e1"); push(P2, "e2");
      pop('0, 1'b0, 1'b1, 0, "nan0");
      pop('0, 1'b0, 1'b1, 0, "nan1");
      pop('0, 1'b1, 1'b1, 0, "nan2");
      push(P2, "c0"); push(P3, "c1"); push(P1, "c2");
      pop(P1, 1'b0, 1'b0, 1, "clean0");
      pop(P2, 1'b0, 1'b0, 1, "clean1");
      pop(P3, 1'b1, 1'b0, 1, "clean2");

      // Upstream gaps: valid pattern 1,0,0,1,0,1 carrying 3.0, 1.0, 2.0.
      begin
         logic [5:0]  pat;
         logic [63:0] vals [3];
         int          k;
         pat = 6'b101001;
         vals[0] = P3; vals[1] = P1; vals[2] = P2;
         k = 0;
         for (int i = 0; i < 6; i++) begin
            up_valid = pat[i];
            up_data  = pat[i] ? vals[k] : JNK;
            if (pat[i]) k++;
            @(posedge clk); #1;
         end
         up_valid = 1'b0;
         up_data  = JNK;
      end
      pop(P1, 1'b0, 1'b0, 1, "gap0");
      pop(P2, 1'b0, 1'b0, 1, "gap1");
      pop(P3, 1'b1, 1'b0, 1, "gap2");

      // Asynchronous reset at beat 1 of an emission.
      push(M1, "a0"); push(P3, "a1"); push(P2, "a2");
      pop(M1, 1'b0, 1'b0, 1, "ar0");
      check("ar_pre_vld", down_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_vld", down_valid, 1'b0);
      check("ar_data", down_data, 64'h0);
      check("ar_upr", up_ready, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ar_rel_upr", up_ready, 1'b1);
      check("ar_rel_vld", down_valid, 1'b0);
      push(P2, "q0");
      check("ar_nostale", down_valid, 1'b0);
      push(P1, "q1"); push(P3, "q2");
      pop(P1, 1'b0, 1'b0, 1, "arn0");
      pop(P2, 1'b0, 1'b0, 1, "arn1");
      pop(P3, 1'b1, 1'b0, 1, "arn2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
